// File: rtl/apb_intc_pkg.sv
// Shared definitions for the APB interrupt controller: register map and
// address decode helper.
package apb_intc_pkg;

  localparam logic [3:0] INTC_STATUS = 4'h0;
  localparam logic [3:0] INTC_ENABLE = 4'h4;
  localparam logic [3:0] INTC_EDGE   = 4'h8;
  localparam logic [3:0] INTC_VECTOR = 4'hC;

  localparam int APB_DATA_W = 32;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_STATUS,
    REG_ENABLE,
    REG_EDGE,
    REG_VECTOR
  } reg_sel_e;

  // Full 4-bit compare so that misaligned byte addresses read as unmapped.
  function automatic reg_sel_e decodeAddr(input logic [3:0] addr);
    reg_sel_e sel;
    case (addr)
      INTC_STATUS: sel = REG_STATUS;
      INTC_ENABLE: sel = REG_ENABLE;
      INTC_EDGE:   sel = REG_EDGE;
      INTC_VECTOR: sel = REG_VECTOR;
      default:     sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/apb_intc_prio_enc.sv
// Combinational priority encoder: lowest set request index wins, id is 0 when
// no request is set.
module apb_intc_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 4
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  // Scanning downward lets the lowest index overwrite any higher one.
  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_intc.sv
// APB interrupt controller: samples irq sources, latches level/edge pending
// bits, masks with ENABLE and drives a registered cpu_int plus a VECTOR register.
module apb_intc
  import apb_intc_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 4
) (
  input  logic               apb_pclk_i,
  input  logic               apb_prst_i,
  input  logic               apb_psel_i,
  input  logic [3:0]         apb_paddr_i,
  input  logic               apb_pwrite_i,
  input  logic               apb_penable_i,
  input  logic [31:0]        apb_pwdata_i,
  output logic [31:0]        apb_prdata_o,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic               cpu_int_o
);

  logic               wrEn;
  logic               rdEn;
  reg_sel_e           regSel;
  logic [NUM_SRC-1:0] wrBits;
  logic [NUM_SRC-1:0] riseDet;
  logic [NUM_SRC-1:0] statusClr;
  logic [NUM_SRC-1:0] maskedPend;
  logic               vecValid;
  logic [ID_W-1:0]    vecId;
  logic               unusedWdata;

  logic [NUM_SRC-1:0] srcSync_q;
  logic [NUM_SRC-1:0] srcDly_q;
  logic [NUM_SRC-1:0] pending_q,  pending_d;
  logic [NUM_SRC-1:0] enable_q,   enable_d;
  logic [NUM_SRC-1:0] edgeMode_q, edgeMode_d;
  logic               cpuInt_q,   cpuInt_d;

  assign wrEn        = apb_psel_i & apb_penable_i & apb_pwrite_i;
  assign rdEn        = apb_psel_i & apb_penable_i & ~apb_pwrite_i;
  assign regSel      = decodeAddr(apb_paddr_i);
  assign wrBits      = apb_pwdata_i[NUM_SRC-1:0];
  assign unusedWdata = ^apb_pwdata_i[APB_DATA_W-1:NUM_SRC];

  assign riseDet    = srcSync_q & ~srcDly_q;
  assign statusClr  = (wrEn && (regSel == REG_STATUS)) ? wrBits : '0;
  assign maskedPend = pending_q & enable_q;

  // Edge bits: rise is OR-ed in after the clear so a coincident edge is never lost.
  always_comb begin
    pending_d  = (edgeMode_q & ((pending_q & ~statusClr) | riseDet))
               | (~edgeMode_q & srcSync_q);
    enable_d   = enable_q;
    edgeMode_d = edgeMode_q;
    if (wrEn && (regSel == REG_ENABLE)) begin
      enable_d = wrBits;
    end
    if (wrEn && (regSel == REG_EDGE)) begin
      edgeMode_d = wrBits;
    end
    cpuInt_d = |maskedPend;
  end

  always_ff @(posedge apb_pclk_i) begin
    if (apb_prst_i) begin
      srcSync_q  <= '0;
      srcDly_q   <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      edgeMode_q <= '0;
      cpuInt_q   <= 1'b0;
    end else begin
      srcSync_q  <= irq_src_i;
      srcDly_q   <= srcSync_q;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      edgeMode_q <= edgeMode_d;
      cpuInt_q   <= cpuInt_d;
    end
  end

  apb_intc_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req_i   (maskedPend),
    .valid_o (vecValid),
    .id_o    (vecId)
  );

  // Read mux is combinational so there are no wait states on reads.
  always_comb begin
    apb_prdata_o = '0;
    if (rdEn) begin
      case (regSel)
        REG_STATUS: apb_prdata_o[NUM_SRC-1:0] = pending_q;
        REG_ENABLE: apb_prdata_o[NUM_SRC-1:0] = enable_q;
        REG_EDGE:   apb_prdata_o[NUM_SRC-1:0] = edgeMode_q;
        REG_VECTOR: begin
          apb_prdata_o[APB_DATA_W-1] = vecValid;
          apb_prdata_o[ID_W-1:0]     = vecId;
        end
        default: apb_prdata_o = '0;
      endcase
    end
  end

  assign cpu_int_o = cpuInt_q;

endmodule

// File: tb/tb_apb_intc.sv
// Cycle-accurate bench for apb_intc: table of single-cycle APB access phases with
// expected read data and cpu_int, plus hand-written edge/reset sequences.
module tb_apb_intc;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 4;

  typedef enum logic [1:0] {OP_IDLE, OP_WR, OP_RD} op_e;

  typedef struct {
    string       name;
    logic        rst;
    logic [7:0]  irq;
    op_e         op;
    logic [3:0]  addr;
    logic [31:0] wdata;
    bit          chkRd;
    logic [31:0] expRd;
    bit          chkInt;
    logic        expInt;
  } vec_t;

  typedef struct {
    string       name;
    bit          chkRd;
    logic [31:0] expRd;
    bit          chkInt;
    logic        expInt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel;
  logic [3:0]  paddr;
  logic        pwrite;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic [7:0]  irqSrc;
  logic        cpuInt;

  vec_t tbl[$];
  exp_t sbQ[$];
  int   vecCount  = 0;
  int   missCount = 0;

  always #5 clk = ~clk;

  apb_intc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) dut (
    .apb_pclk_i    (clk),
    .apb_prst_i    (rst),
    .apb_psel_i    (psel),
    .apb_paddr_i   (paddr),
    .apb_pwrite_i  (pwrite),
    .apb_penable_i (penable),
    .apb_pwdata_i  (pwdata),
    .apb_prdata_o  (prdata),
    .irq_src_i     (irqSrc),
    .cpu_int_o     (cpuInt)
  );

  function automatic vec_t mkVec(input string name, input logic rstIn, input logic [7:0] irq,
                                 input op_e op, input logic [3:0] addr, input logic [31:0] wdata,
                                 input bit chkRd, input logic [31:0] expRd,
                                 input bit chkInt, input logic expInt);
    vec_t v;
    v.name = name; v.rst = rstIn; v.irq = irq; v.op = op; v.addr = addr; v.wdata = wdata;
    v.chkRd = chkRd; v.expRd = expRd; v.chkInt = chkInt; v.expInt = expInt;
    return v;
  endfunction

  // Drives one cycle just after the rising edge and queues what must be seen.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst     = v.rst;
    irqSrc  = v.irq;
    psel    = (v.op != OP_IDLE);
    penable = (v.op != OP_IDLE);
    pwrite  = (v.op == OP_WR);
    paddr   = v.addr;
    pwdata  = v.wdata;
    e.name = v.name; e.chkRd = v.chkRd; e.expRd = v.expRd;
    e.chkInt = v.chkInt; e.expInt = v.expInt;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(negedge clk);
    e = sbQ.pop_front();
    if (e.chkRd) begin
      vecCount++;
      if (prdata !== e.expRd) begin
        missCount++;
        $display("[TB] FAIL %s prdata: got %h want %h", e.name, prdata, e.expRd);
      end
    end
    if (e.chkInt) begin
      vecCount++;
      if (cpuInt !== e.expInt) begin
        missCount++;
        $display("[TB] FAIL %s cpu_int: got %b want %b", e.name, cpuInt, e.expInt);
      end
    end
  endtask

  task automatic step(input string name, input logic rstIn, input logic [7:0] irq, input op_e op,
                      input logic [3:0] addr, input logic [31:0] wdata,
                      input bit chkRd, input logic [31:0] expRd,
                      input bit chkInt, input logic expInt);
    applyStimulus(mkVec(name, rstIn, irq, op, addr, wdata, chkRd, expRd, chkInt, expInt));
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; irqSrc = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;

    tbl.push_back(mkVec("rst STATUS",      0, 8'h00, OP_RD,   4'h0, 32'h0,        1, 32'h0,        1, 0));
    tbl.push_back(mkVec("rst ENABLE",      0, 8'h00, OP_RD,   4'h4, 32'h0,        1, 32'h0,        1, 0));
    tbl.push_back(mkVec("rst EDGE",        0, 8'h00, OP_RD,   4'h8, 32'h0,        1, 32'h0,        1, 0));
    tbl.push_back(mkVec("rst VECTOR",      0, 8'h00, OP_RD,   4'hC, 32'h0,        1, 32'h0,        1, 0));
    tbl.push_back(mkVec("lvl wr ENABLE",   0, 8'h00, OP_WR,   4'h4, 32'h01,       1, 32'h0,        1, 0));
    tbl.push_back(mkVec("lvl wr EDGE",     0, 8'h01, OP_WR,   4'h8, 32'h00,       1, 32'h0,        1, 0));
    tbl.push_back(mkVec("lvl STATUS lat",  0, 8'h01, OP_RD,   4'h0, 32'h0,        1, 32'h0,        1, 0));
    tbl.push_back(mkVec("lvl STATUS set",  0, 8'h01, OP_RD,   4'h0, 32'h0,        1, 32'h01,       1, 0));
    tbl.push_back(mkVec("lvl VECTOR",      0, 8'h01, OP_RD,   4'hC, 32'h0,        1, 32'h80000000, 1, 1));
    tbl.push_back(mkVec("lvl drop 0",      0, 8'h00, OP_IDLE, 4'h0, 32'h0,        1, 32'h0,        1, 1));
    tbl.push_back(mkVec("lvl drop 1",      0, 8'h00, OP_IDLE, 4'h0, 32'h0,        0, 32'h0,        1, 1));
    tbl.push_back(mkVec("lvl STATUS clr",  0, 8'h00, OP_RD,   4'h0, 32'h0,        1, 32'h0,        1, 1));
    tbl.push_back(mkVec("edg wr EDGE",     0, 8'h00, OP_WR,   4'h8, 32'h04,       1, 32'h0,        1, 0));
    tbl.push_back(mkVec("edg wr ENABLE",   0, 8'h00, OP_WR,   4'h4, 32'h04,       1, 32'h0,        1, 0));
    tbl.push_back(mkVec("edg pulse",       0, 8'h04, OP_IDLE, 4'h0, 32'h0,        0, 32'h0,        1, 0));
    tbl.push_back(mkVec("edg EDGE rd",     0, 8'h00, OP_RD,   4'h8, 32'h0,        1, 32'h04,       1, 0));
    tbl.push_back(mkVec("edg STATUS set",  0, 8'h00, OP_RD,   4'h0, 32'h0,        1, 32'h04,       1, 0));
    tbl.push_back(mkVec("edg VECTOR",      0, 8'h00, OP_RD,   4'hC, 32'h0,        1, 32'h80000002, 1, 1));
    tbl.push_back(mkVec("edg STATUS hold", 0, 8'h00, OP_RD,   4'h0, 32'h0,        1, 32'h04,       1, 1));
    tbl.push_back(mkVec("edg w1c",         0, 8'h00, OP_WR,   4'h0, 32'h04,       1, 32'h0,        1, 1));
    tbl.push_back(mkVec("edg STATUS clr",  0, 8'h00, OP_RD,   4'h0, 32'h0,        1, 32'h0,        1, 1));
    tbl.push_back(mkVec("edg int drop",    0, 8'h00, OP_RD,   4'h0, 32'h0,        1, 32'h0,        1, 0));
    tbl.push_back(mkVec("pri wr ENABLE",   0, 8'h00, OP_WR,   4'h4, 32'hFFFFFFFF, 1, 32'h0,        1, 0));
    tbl.push_back(mkVec("pri wr EDGE",     0, 8'h00, OP_WR,   4'h8, 32'h00000148, 1, 32'h0,        1, 0));
    tbl.push_back(mkVec("pri ENABLE rd",   0, 8'h00, OP_RD,   4'h4, 32'h0,        1, 32'hFF,       1, 0));
    tbl.push_back(mkVec("pri EDGE rd",     0, 8'h48, OP_RD,   4'h8, 32'h0,        1, 32'h48,       1, 0));
    tbl.push_back(mkVec("pri idle",        0, 8'h00, OP_IDLE, 4'h0, 32'h0,        1, 32'h0,        1, 0));
    tbl.push_back(mkVec("pri STATUS",      0, 8'h00, OP_RD,   4'h0, 32'h0,        1, 32'h48,       1, 0));
    tbl.push_back(mkVec("pri VECTOR 3",    0, 8'h00, OP_RD,   4'hC, 32'h0,        1, 32'h80000003, 1, 1));
    tbl.push_back(mkVec("pri w1c bit3",    0, 8'h00, OP_WR,   4'h0, 32'h08,       1, 32'h0,        1, 1));
    tbl.push_back(mkVec("pri VECTOR 6",    0, 8'h00, OP_RD,   4'hC, 32'h0,        1, 32'h80000006, 1, 1));
    tbl.push_back(mkVec("pri ENABLE off",  0, 8'h00, OP_WR,   4'h4, 32'h0,        1, 32'h0,        1, 1));
    tbl.push_back(mkVec("pri VECTOR mask", 0, 8'h00, OP_RD,   4'hC, 32'h0,        1, 32'h0,        1, 1));
    tbl.push_back(mkVec("pri STATUS raw",  0, 8'h00, OP_RD,   4'h0, 32'h0,        1, 32'h40,       1, 0));
    tbl.push_back(mkVec("unmapped rd",     0, 8'h00, OP_RD,   4'h2, 32'h0,        1, 32'h0,        1, 0));
    tbl.push_back(mkVec("VECTOR wr",       0, 8'h00, OP_WR,   4'hC, 32'hFFFFFFFF, 1, 32'h0,        1, 0));
    tbl.push_back(mkVec("VECTOR after wr", 0, 8'h00, OP_RD,   4'hC, 32'h0,        1, 32'h0,        1, 0));

    repeat (3) @(posedge clk);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput();
    end

    // W1C and a fresh rising edge land on the same clock: the edge must win.
    step("sim wr EDGE",     0, 8'h00, OP_WR,   4'h8, 32'h20, 1, 32'h0,        1, 0);
    step("sim wr ENABLE",   0, 8'h00, OP_WR,   4'h4, 32'h20, 1, 32'h0,        1, 0);
    step("sim pulse a",     0, 8'h20, OP_IDLE, 4'h0, 32'h0,  0, 32'h0,        1, 0);
    step("sim low",         0, 8'h00, OP_IDLE, 4'h0, 32'h0,  0, 32'h0,        1, 0);
    step("sim STATUS a",    0, 8'h00, OP_RD,   4'h0, 32'h0,  1, 32'h20,       1, 0);
    step("sim pulse b",     0, 8'h20, OP_RD,   4'hC, 32'h0,  1, 32'h80000005, 1, 1);
    step("sim w1c+edge",    0, 8'h00, OP_WR,   4'h0, 32'h20, 1, 32'h0,        1, 1);
    step("sim edge wins",   0, 8'h00, OP_RD,   4'h0, 32'h0,  1, 32'h20,       1, 1);
    step("sim w1c",         0, 8'h00, OP_WR,   4'h0, 32'h20, 1, 32'h0,        1, 1);
    step("sim STATUS clr",  0, 8'h00, OP_RD,   4'h0, 32'h0,  1, 32'h0,        1, 1);
    step("sim int drop",    0, 8'h00, OP_IDLE, 4'h0, 32'h0,  0, 32'h0,        1, 0);

    // Reset while cpu_int is high and irq_src[1] stays high in edge mode.
    step("rsq wr EDGE",     0, 8'h02, OP_WR,   4'h8, 32'h02, 1, 32'h0,        1, 0);
    step("rsq wr ENABLE",   0, 8'h02, OP_WR,   4'h4, 32'h02, 1, 32'h0,        1, 0);
    step("rsq idle",        0, 8'h02, OP_IDLE, 4'h0, 32'h0,  0, 32'h0,        1, 0);
    step("rsq STATUS",      0, 8'h02, OP_RD,   4'h0, 32'h0,  1, 32'h02,       1, 1);
    step("rsq assert rst",  1, 8'h02, OP_IDLE, 4'h0, 32'h0,  0, 32'h0,        1, 1);
    step("rsq STATUS 0",    0, 8'h02, OP_RD,   4'h0, 32'h0,  1, 32'h0,        1, 0);
    step("rsq EDGE 0",      0, 8'h02, OP_RD,   4'h8, 32'h0,  1, 32'h0,        1, 0);
    step("rsq ENABLE 0",    0, 8'h02, OP_RD,   4'h4, 32'h0,  1, 32'h0,        1, 0);
    step("rsq re EDGE",     0, 8'h02, OP_WR,   4'h8, 32'h02, 1, 32'h0,        1, 0);
    step("rsq re ENABLE",   0, 8'h02, OP_WR,   4'h4, 32'h02, 1, 32'h0,        1, 0);
    step("rsq lvl retain",  0, 8'h02, OP_RD,   4'h0, 32'h0,  1, 32'h02,       1, 0);
    step("rsq w1c",         0, 8'h02, OP_WR,   4'h0, 32'h02, 1, 32'h0,        1, 1);
    step("rsq clr int",     0, 8'h02, OP_IDLE, 4'h0, 32'h0,  0, 32'h0,        1, 1);
    step("rsq no retrig",   0, 8'h02, OP_RD,   4'h0, 32'h0,  1, 32'h0,        1, 0);
    step("rsq held low",    0, 8'h00, OP_RD,   4'h0, 32'h0,  1, 32'h0,        1, 0);
    step("rsq fresh rise",  0, 8'h02, OP_IDLE, 4'h0, 32'h0,  0, 32'h0,        1, 0);
    step("rsq sync",        0, 8'h02, OP_IDLE, 4'h0, 32'h0,  0, 32'h0,        1, 0);
    step("rsq STATUS new",  0, 8'h02, OP_RD,   4'h0, 32'h0,  1, 32'h02,       1, 0);
    step("rsq VECTOR 1",    0, 8'h02, OP_RD,   4'hC, 32'h0,  1, 32'h80000001, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
